// File: rtl/terminal_pkg.sv
// Shared constants and types for the text-terminal write path.
// The terminal is an 80x30 character buffer addressed linearly, 0 .. 2399.
package terminal_pkg;

  localparam int TERMINAL_COLUMN_MAX = 80;
  localparam int TERMINAL_ROW_MAX = 30;
  localparam int TERMINAL_ADDR_MAX = TERMINAL_COLUMN_MAX * TERMINAL_ROW_MAX - 1;
  localparam int TERMINAL_ADDR_WIDTH = 12;
  localparam logic [7:0] TERMINAL_CLEAR_CHAR = 8'h20;

  typedef enum logic {
    ARB   = 1'b0,
    CLEAR = 1'b1
  } state_t;

  // Width of a requester index; never zero, even for a single requester.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first set request at or after ptr, wrapping.
// The pointer register lives in the caller.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx,
  output logic          any_grant
);

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!any_grant && req[(int'(ptr) + k) % N]) begin
        grant[(int'(ptr) + k) % N] = 1'b1;
        grant_idx = PW'((int'(ptr) + k) % N);
        any_grant = 1'b1;
      end
    end
  end

endmodule

// File: rtl/terminal_write_arbiter.sv
// Shares the terminal RAM write port among NUM_REQ requesters (round robin) and
// runs a full-screen clear sequence on request.
module terminal_write_arbiter
  import terminal_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = TERMINAL_ADDR_WIDTH,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_MAX   = TERMINAL_ADDR_MAX,
  parameter logic [DATA_WIDTH-1:0] CLEAR_CHAR = TERMINAL_CLEAR_CHAR
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic                          clear_start,
  output logic                          clear_busy,
  output logic                          addr_error,
  output logic [ADDR_WIDTH-1:0]         terminal_addr,
  output logic [DATA_WIDTH-1:0]         terminal_data,
  output logic                          terminal_write,
  output state_t                        debug_state
);

  localparam int PTR_W = ptr_width(NUM_REQ);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(ADDR_MAX);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

  state_t                  state_q, state_d;
  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_d;
  logic [DATA_WIDTH-1:0]   data_d;
  logic                    write_d;
  logic                    err_d;
  logic [NUM_REQ-1:0]      ready_c;

  logic [NUM_REQ-1:0]      grant;
  logic [PTR_W-1:0]        grant_idx;
  logic                    any_grant;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_data;

  rr_arbiter #(
    .N  (NUM_REQ),
    .PW (PTR_W)
  ) u_rr_arbiter (
    .req       (req_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  assign sel_addr = req_addr[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_data = req_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];

  // Handshake: requester i transfers on a cycle where req_valid[i] & req_ready[i];
  // it must hold valid/addr/data stable until then. Ready is combinational, at
  // most one bit high, and never depends on ready from the previous cycle.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    addr_d  = terminal_addr;
    data_d  = terminal_data;
    write_d = 1'b0;
    err_d   = addr_error;
    ready_c = '0;
    case (state_q)
      ARB: begin
        if (clear_start) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end else if (any_grant) begin
          ready_c = grant;
          ptr_d   = (grant_idx == PTR_LAST) ? '0 : grant_idx + 1'b1;
          // Out-of-range requests are consumed so the requester never stalls.
          if (sel_addr > ADDR_LAST) begin
            err_d = 1'b1;
          end else begin
            write_d = 1'b1;
            addr_d  = sel_addr;
            data_d  = sel_data;
          end
        end
      end
      CLEAR: begin
        write_d = 1'b1;
        addr_d  = cnt_q;
        data_d  = CLEAR_CHAR;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == ADDR_LAST) begin
          state_d = ARB;
          cnt_d   = '0;
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ARB;
      ptr_q          <= '0;
      cnt_q          <= '0;
      terminal_addr  <= '0;
      terminal_data  <= '0;
      terminal_write <= 1'b0;
      addr_error     <= 1'b0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      cnt_q          <= cnt_d;
      terminal_addr  <= addr_d;
      terminal_data  <= data_d;
      terminal_write <= write_d;
      addr_error     <= err_d;
    end
  end

  assign req_ready   = ready_c & {NUM_REQ{reset_n}};
  assign clear_busy  = (state_q == CLEAR);
  assign debug_state = state_q;

endmodule

// File: doc/terminal_write_arbiter.md
Name: terminal_write_arbiter

Overview:
- Shares the single text-terminal write port (80x30 character buffer, addresses 0..2399) among NUM_REQ requesters, e.g. the register-dump debugger scanner and a CPU memory-mapped console.
- Uses round-robin arbitration with a valid/ready handshake per requester.
- Contains a clear-screen sequencer that fills the whole buffer with a blank character on command.
- Sits between the requesters and the terminal/VGA text RAM write port.

Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- ADDR_WIDTH, 12, terminal address width
- DATA_WIDTH, 8, character width
- ADDR_MAX, 2399, last valid terminal address (80*30-1)
- CLEAR_CHAR, 8'h20, character written during clear

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  reset, asynchronous, active-low
- req_valid  in  NUM_REQ  per-requester write request
- req_ready  out  NUM_REQ  per-requester accept; transfer when valid&ready
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_data  in  NUM_REQ*DATA_WIDTH  packed characters; requester i at [i*DATA_WIDTH +: DATA_WIDTH]
- clear_start  in  1  one-cycle pulse; start a full-screen clear
- clear_busy  out  1  high while the clear is in progress
- addr_error  out  1  sticky; a request with address > ADDR_MAX was dropped
- terminal_addr  out  ADDR_WIDTH  registered write address
- terminal_data  out  DATA_WIDTH  registered write character
- terminal_write  out  1  registered write strobe, one cycle per write

Behaviour:
- Reset (async, reset_n=0):
  - state=ARB, rr pointer=0.
  - terminal_addr=0, terminal_data=0, terminal_write=0.
  - clear_busy=0, addr_error=0, req_ready=0 while reset is asserted.
- States: ARB, CLEAR.
- ARB:
  - Grant = first requester with req_valid high, searching pointer, pointer+1, ... modulo NUM_REQ.
  - req_ready is combinational: one-hot on the granted index, all zero if no valid request or if clear_start=1.
  - At most one transfer per cycle.
  - On a transfer from requester i: pointer <= (i+1) mod NUM_REQ.
  - The pointer is unchanged when no transfer occurs.
- Write latency: a transfer at edge t drives terminal_addr/data at t+1 with terminal_write=1 for exactly one cycle. terminal_write=0 on any cycle without a transfer. terminal_addr/data hold their last value when idle.
- Out-of-range address (req_addr > ADDR_MAX):
  - The request is still accepted (ready=1) and the pointer advances.
  - No terminal write occurs.
  - addr_error sets and stays set until reset.
- clear_start in ARB:
  - Takes priority over every request in the same cycle.
  - No transfer that cycle; next state CLEAR.
  - Internal clear counter=0; clear_busy=1 from the next cycle.
- CLEAR:
  - req_ready=0 for all requesters.
  - Each cycle writes CLEAR_CHAR to the counter address, with terminal_write=1 in every cycle at registered timing, then increments the counter.
  - After the write of address ADDR_MAX, return to ARB; clear_busy drops in the same cycle the ARB state begins.
  - Exactly ADDR_MAX+1 consecutive write strobes are produced.
  - clear_start during CLEAR is ignored and does not restart the clear.
  - The pointer is preserved across the clear.
- Reset asserted mid-clear aborts immediately. All outputs return to reset values and no further clear writes occur.
- Requesters must hold valid, addr and data stable until ready; the arbiter does not buffer them.
- The counter compare uses ADDR_WIDTH bits. The counter never exceeds ADDR_MAX, so there is no wrap-around.

Decomposition:
- Shared package terminal_pkg:
  - TERMINAL_COLUMN_MAX=80, TERMINAL_ROW_MAX=30, TERMINAL_ADDR_MAX=2399, TERMINAL_ADDR_WIDTH=12.
  - CLEAR_CHAR default.
  - State enum {ARB, CLEAR}.
- One sub-module, rr_arbiter: purely combinational. Inputs are the request vector and pointer; outputs are the one-hot grant, grant index and any_grant. Pointer state is held in terminal_write_arbiter.

Test Plan:
- Reset: assert reset_n=0 mid-run.
  - Expect terminal_write=0, terminal_addr=0, clear_busy=0, addr_error=0, req_ready=0.
  - After release, the first transfer goes to req0 when both requesters are valid.
- Single write: req1 valid with addr=85, data=8'h41.
  - Expect ready1=1 the same cycle.
  - Next cycle: terminal_write=1, terminal_addr=85, terminal_data=8'h41; the following cycle terminal_write=0.
- Fairness: req0 and req1 held valid continuously for 6 cycles.
  - Expect grants 0,1,0,1,0,1 and exactly 6 write strobes in order.
- Out-of-range: req0 addr=2400.
  - Expect ready0=1, no terminal_write, addr_error=1 sticky through later valid writes.
- Clear collision: clear_start and req0 valid in the same cycle.
  - Expect ready0=0 for 2400 cycles and clear_busy=1.
  - Expect 2400 strobes, addresses 0..2399 in order, all data 8'h20.
  - A second clear_start mid-clear has no effect.
  - Afterwards req0 is accepted on the first ARB cycle.
- Reset mid-clear: assert reset_n at counter=1000.
  - Expect immediate terminal_write=0 and clear_busy=0.
  - After release, state is ARB with no further clear writes.
